// File: rtl/display_share_arbiter_pkg.sv
// Shared types and default timing constants for the display-sharing arbiter.
package display_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam int unsigned DEF_NREQ         = 3;
  localparam int unsigned DEF_W            = 16;
  localparam int unsigned DEF_HOLD_CYCLES  = 100_000_000;
  localparam int unsigned DEF_BLANK_CYCLES = 1_000_000;

endpackage

// File: rtl/display_share_arbiter_rr_pick.sv
// Round-robin picker: first set request after i_ptr, wrapping modulo NREQ.
module display_share_arbiter_rr_pick
  import display_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [$clog2(NREQ)-1:0] o_winner,
  output logic                    o_any_req
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0] w_idx;

  // Scan farthest-first so the nearest set bit after i_ptr overwrites the result
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_idx = PW'((int'(i_ptr) + k) % int'(NREQ));
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/display_share_arbiter.sv
// Shares one 4-digit display between NREQ producers: round-robin ownership
// with a minimum hold time and a blanking gap between owners.
module display_share_arbiter
  import display_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ         = DEF_NREQ,
  parameter int unsigned W            = DEF_W,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] data_in,
  output logic [NREQ-1:0] grant,
  output logic [W-1:0]    dataword,
  output logic            blank,
  output logic            new_owner
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PW-1:0]   r_ptr;
  logic [HW-1:0]   r_hold_cnt;
  logic [BW-1:0]   r_blank_cnt;

  logic [PW-1:0]   w_winner;
  logic            w_any_req;
  logic [W-1:0]    w_words [NREQ];
  logic [NREQ-1:0] w_owner_mask;
  logic            w_owner_req;
  logic            w_other_req;
  logic            w_hold_done;
  logic            w_blank_done;
  logic            w_take;

  logic [NREQ-1:0] w_grant_nxt;
  logic            w_blank_nxt;
  logic [W-1:0]    w_data_nxt;
  logic            w_new_owner_nxt;
  logic [HW-1:0]   w_hold_nxt;
  logic [BW-1:0]   w_blank_cnt_nxt;
  logic [PW-1:0]   w_ptr_nxt;

  // r_ptr always holds the current (or most recent) owner index
  display_share_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_words
    assign w_words[g] = data_in[g*W +: W];
  end

  assign w_owner_mask = NREQ'(1) << r_ptr;
  assign w_owner_req  = req[r_ptr];
  assign w_other_req  = |(req & ~w_owner_mask);
  assign w_hold_done  = (r_hold_cnt == HW'(HOLD_CYCLES));
  assign w_blank_done = (r_blank_cnt == BW'(BLANK_CYCLES));
  assign w_take       = (w_state_nxt == ST_OWN) && (r_state != ST_OWN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: release or post-hold pre-emption leaves OWN through a single BLANK
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_OWN;
      ST_OWN:   if (!w_owner_req || (w_hold_done && w_other_req)) w_state_nxt = ST_BLANK;
      ST_BLANK: if (w_blank_done) w_state_nxt = w_any_req ? ST_OWN : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/counter next values, keyed on the transition being taken
  always_comb begin
    w_grant_nxt     = grant;
    w_blank_nxt     = blank;
    w_data_nxt      = dataword;
    w_new_owner_nxt = 1'b0;
    w_hold_nxt      = r_hold_cnt;
    w_blank_cnt_nxt = r_blank_cnt;
    w_ptr_nxt       = r_ptr;
    if (w_take) begin
      w_ptr_nxt       = w_winner;
      w_grant_nxt     = NREQ'(1) << w_winner;
      w_blank_nxt     = 1'b0;
      w_data_nxt      = w_words[w_winner];
      w_new_owner_nxt = 1'b1;
      w_hold_nxt      = '0;
      w_blank_cnt_nxt = '0;
    end else begin
      unique case (w_state_nxt)
        ST_OWN: begin
          w_grant_nxt = w_owner_mask;
          w_blank_nxt = 1'b0;
          w_data_nxt  = w_words[r_ptr];
          if (!w_hold_done) w_hold_nxt = r_hold_cnt + HW'(1);
        end
        ST_BLANK: begin
          w_grant_nxt     = '0;
          w_blank_nxt     = 1'b1;
          w_hold_nxt      = '0;
          w_blank_cnt_nxt = (r_state == ST_BLANK) ? r_blank_cnt + BW'(1) : BW'(1);
        end
        default: begin
          w_grant_nxt     = '0;
          w_blank_nxt     = 1'b1;
          w_blank_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Registered outputs, counters and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      dataword    <= '0;
      blank       <= 1'b1;
      new_owner   <= 1'b0;
      r_hold_cnt  <= '0;
      r_blank_cnt <= '0;
      r_ptr       <= PW'(NREQ - 1);
    end else begin
      grant       <= w_grant_nxt;
      dataword    <= w_data_nxt;
      blank       <= w_blank_nxt;
      new_owner   <= w_new_owner_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_blank_cnt <= w_blank_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

endmodule
